// File: rtl/dout_uart_tx.sv
// Byte sink for the core's dout port: small FIFO feeding an 8N1 UART transmitter.
// Optional even-parity frame (8E1) when DOUT_TX_PARITY_EN is defined.
module dout_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       full,
  output logic       ovf,
  output logic       busy,
  output logic       tx
);

  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [AddrW:0]  FullCnt  = (AddrW + 1)'(FIFO_DEPTH);
  localparam logic [CntW-1:0] BaudLast = CntW'(CLKS_PER_BIT - 1);

`ifdef DOUT_TX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  // FIFO storage and bookkeeping
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [AddrW-1:0] r_wptr;
  logic [AddrW-1:0] r_rptr;
  logic [AddrW:0]   r_count;
  logic             r_ovf;
  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic [7:0]       w_head;

  // Transmitter state
  state_e          r_state;
  state_e          w_state_d;
  logic [CntW-1:0] r_baud;
  logic [CntW-1:0] w_baud_d;
  logic [2:0]      r_bit_idx;
  logic [2:0]      w_bit_d;
  logic [7:0]      r_shift;
  logic [7:0]      w_shift_d;
  logic            r_tx;
  logic            w_tx_d;
  logic            w_baud_last;
`ifdef DOUT_TX_PARITY_EN
  logic            r_parity;
  logic            w_parity_d;
`endif

  assign full    = (r_count == FullCnt);
  assign w_empty = (r_count == '0);
  assign w_push  = din_valid & ~full;
  assign w_head  = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // Dropped write: full is the pre-edge value, so a same-edge pop does not rescue it.
      if (din_valid && full) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign w_baud_last = (r_baud == BaudLast);

  always_comb begin
    w_state_d = r_state;
    w_baud_d  = r_baud + 1'b1;
    w_bit_d   = r_bit_idx;
    w_shift_d = r_shift;
    w_pop     = 1'b0;
`ifdef DOUT_TX_PARITY_EN
    w_parity_d = r_parity;
`endif
    unique case (r_state)
      StIdle: begin
        w_baud_d = '0;
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_shift_d = w_head;
          w_state_d = StStart;
`ifdef DOUT_TX_PARITY_EN
          w_parity_d = ^w_head;
`endif
        end
      end
      StStart: begin
        if (w_baud_last) begin
          w_baud_d  = '0;
          w_bit_d   = '0;
          w_state_d = StData;
        end
      end
      StData: begin
        if (w_baud_last) begin
          w_baud_d  = '0;
          w_shift_d = {1'b0, r_shift[7:1]};
          if (r_bit_idx == 3'd7) begin
`ifdef DOUT_TX_PARITY_EN
            w_state_d = StParity;
`else
            w_state_d = StStop;
`endif
          end else begin
            w_bit_d = r_bit_idx + 3'd1;
          end
        end
      end
`ifdef DOUT_TX_PARITY_EN
      StParity: begin
        if (w_baud_last) begin
          w_baud_d  = '0;
          w_state_d = StStop;
        end
      end
`endif
      StStop: begin
        if (w_baud_last) begin
          w_baud_d = '0;
          // Chain straight into the next frame when more data is waiting.
          if (!w_empty) begin
            w_pop     = 1'b1;
            w_shift_d = w_head;
            w_state_d = StStart;
`ifdef DOUT_TX_PARITY_EN
            w_parity_d = ^w_head;
`endif
          end else begin
            w_state_d = StIdle;
          end
        end
      end
      default: begin
        w_baud_d  = '0;
        w_state_d = StIdle;
      end
    endcase
  end

  // Line level is derived from the next state so tx is a clean register output.
  always_comb begin
    case (w_state_d)
      StStart:  w_tx_d = 1'b0;
      StData:   w_tx_d = w_shift_d[0];
`ifdef DOUT_TX_PARITY_EN
      StParity: w_tx_d = w_parity_d;
`endif
      default:  w_tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
`ifdef DOUT_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_d;
      r_baud    <= w_baud_d;
      r_bit_idx <= w_bit_d;
      r_shift   <= w_shift_d;
      r_tx      <= w_tx_d;
`ifdef DOUT_TX_PARITY_EN
      r_parity  <= w_parity_d;
`endif
    end
  end

  assign ovf  = r_ovf;
  assign busy = (r_state != StIdle);
  assign tx   = r_tx;

endmodule

// File: tb/tb_dout_uart_tx.sv
// Scoreboard bench for dout_uart_tx: stimulus queues expected bytes, a line monitor
// decodes frames from tx and checks them against the queue.
module tb_dout_uart_tx;

  localparam int unsigned Cpb   = 4;
  localparam int unsigned Depth = 4;
`ifdef DOUT_TX_PARITY_EN
  localparam int FrameBits = 11;
`else
  localparam int FrameBits = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;
  logic       full;
  logic       ovf;
  logic       busy;
  logic       tx;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  int         busy_cycles = 0;
  int         busy_falls = 0;
  logic       busy_prev = 1'b0;
  int         frames_rx = 0;
  logic       last_par = 1'b0;

  always #10 clk = ~clk;

  dout_uart_tx #(
    .CLKS_PER_BIT(Cpb),
    .FIFO_DEPTH  (Depth)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .din_valid(din_valid),
    .full     (full),
    .ovf      (ovf),
    .busy     (busy),
    .tx       (tx)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (busy === 1'b1) busy_cycles <= busy_cycles + 1;
    if (busy_prev === 1'b1 && busy === 1'b0) busy_falls <= busy_falls + 1;
    busy_prev <= busy;
  end

  // Line monitor: find start bit, sample each bit mid-way, compare with scoreboard.
  initial begin : monitor
    logic [10:0] bits;
    logic [7:0]  exp_b;
    logic        aborted;
    int          w;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && tx === 1'b0) begin
        aborted = 1'b0;
        bits = '0;
        for (int b = 0; b < FrameBits && !aborted; b++) begin
          w = (b == 0) ? Cpb / 2 : Cpb;
          for (int s = 0; s < w; s++) begin
            @(negedge clk);
            if (rst !== 1'b0) aborted = 1'b1;
          end
          bits[b] = tx;
        end
        if (!aborted) begin
          frames_rx++;
          check("rx_start_bit", 32'(bits[0]), 32'd0);
          check("rx_stop_bit", 32'(bits[FrameBits-1]), 32'd1);
`ifdef DOUT_TX_PARITY_EN
          last_par = bits[9];
`endif
          if (exp_q.size() == 0) begin
            check("rx_unexpected_frame", 32'(bits[8:1]), 32'hFFFF_FFFF);
          end else begin
            exp_b = exp_q.pop_front();
            check("rx_byte", 32'(bits[8:1]), 32'(exp_b));
          end
        end
      end
    end
  end

  task automatic push1(input logic [7:0] b, input bit accepted);
    din = b;
    din_valid = 1'b1;
    if (accepted) exp_q.push_back(b);
    @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 2000; i++) begin
      if (busy === 1'b0) break;
      @(negedge clk);
    end
    if (i == 2000) check({name, "_idle_timeout"}, 32'd1, 32'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic watch_line(input int n, output int lows, output int busys);
    lows = 0;
    busys = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
      if (busy !== 1'b0) busys++;
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int b0, f0, r0, lows, busys;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_full", 32'(full), 32'd0);
    check("reset_ovf", 32'(ovf), 32'd0);
    watch_line(50, lows, busys);
    check("idle_tx_low_cycles", 32'(lows), 32'd0);

    // Single byte
    b0 = busy_cycles; f0 = busy_falls; r0 = frames_rx;
    push1(8'hA5, 1'b1);
    din_valid = 1'b0;
    check("single_tx_before_pop", 32'(tx), 32'd1);
    check("single_busy_before_pop", 32'(busy), 32'd0);
    @(negedge clk);
    check("single_tx_start", 32'(tx), 32'd0);
    check("single_busy_start", 32'(busy), 32'd1);
    wait_idle("single");
    check("single_busy_cycles", 32'(busy_cycles - b0), 32'(10 * Cpb + (FrameBits - 10) * Cpb));
    check("single_busy_falls", 32'(busy_falls - f0), 32'd1);
    check("single_frames", 32'(frames_rx - r0), 32'd1);

    // Back-to-back
    b0 = busy_cycles; f0 = busy_falls; r0 = frames_rx;
    push1(8'h01, 1'b1);
    push1(8'h02, 1'b1);
    push1(8'h03, 1'b1);
    din_valid = 1'b0;
    wait_idle("b2b");
    check("b2b_busy_cycles", 32'(busy_cycles - b0), 32'(3 * FrameBits * Cpb));
    check("b2b_busy_falls", 32'(busy_falls - f0), 32'd1);
    check("b2b_frames", 32'(frames_rx - r0), 32'd3);

    // Overflow while a frame is in flight
    r0 = frames_rx;
    check("ovf_clear_before", 32'(ovf), 32'd0);
    push1(8'h3C, 1'b1);
    din_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("ovf_in_flight_busy", 32'(busy), 32'd1);
    push1(8'h11, 1'b1);
    push1(8'h22, 1'b1);
    push1(8'h33, 1'b1);
    check("ovf_not_full_at_3", 32'(full), 32'd0);
    push1(8'h44, 1'b1);
    check("ovf_full_at_4", 32'(full), 32'd1);
    check("ovf_clear_at_4", 32'(ovf), 32'd0);
    push1(8'h55, 1'b0);
    push1(8'h66, 1'b0);
    din_valid = 1'b0;
    check("ovf_set", 32'(ovf), 32'd1);
    check("ovf_full_held", 32'(full), 32'd1);
    wait_idle("ovf");
    check("ovf_frames", 32'(frames_rx - r0), 32'd5);
    check("ovf_sticky", 32'(ovf), 32'd1);
    check("ovf_full_drained", 32'(full), 32'd0);

`ifdef DOUT_TX_PARITY_EN
    b0 = busy_cycles;
    push1(8'h07, 1'b1);
    din_valid = 1'b0;
    wait_idle("par07");
    check("parity_07", 32'(last_par), 32'd1);
    check("parity_07_cycles", 32'(busy_cycles - b0), 32'd44);
    b0 = busy_cycles;
    push1(8'h03, 1'b1);
    din_valid = 1'b0;
    wait_idle("par03");
    check("parity_03", 32'(last_par), 32'd0);
    check("parity_03_cycles", 32'(busy_cycles - b0), 32'd44);
`endif

    // Reset in the middle of DATA bit 3 of byte 0x00
    r0 = frames_rx;
    push1(8'h00, 1'b1);
    push1(8'h5A, 1'b1);
    push1(8'hC3, 1'b1);
    din_valid = 1'b0;
    repeat (16) @(negedge clk);
    check("rstmid_tx_bit3", 32'(tx), 32'd0);
    check("rstmid_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("rstmid_tx", 32'(tx), 32'd1);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_full", 32'(full), 32'd0);
    check("rstmid_ovf", 32'(ovf), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    watch_line(60, lows, busys);
    check("rstmid_tx_low_after", 32'(lows), 32'd0);
    check("rstmid_busy_after", 32'(busys), 32'd0);
    check("rstmid_frames", 32'(frames_rx - r0), 32'd0);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
